// File: rtl/port_arbiter.sv
// -----------------------------------------------------------------------------
// port_arbiter
//
// Routes packets from three non-show-ahead input FIFOs to three outputs.
// Each packet is a header word followed by N payload words. The header holds
// the destination output in bits [1:0] (0 = drop) and N in bits [LEN_W+1:2].
// The header is consumed here; only payload words are forwarded. Payload data
// is not stored: an external mux per output picks data_i using sel_o, and
// out_valid_o marks the cycles in which that data is a payload word.
//
// Every input runs its own small FSM (IDLE, HDR, REQ, XFER, DROP). Every
// output has an owner register and a round-robin pointer, so all three
// outputs can be busy at the same time.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low
//   empty1..3           input FIFO empty flags
//   data1..3   [31:0]   input FIFO read data, valid one cycle after rdreq
//   rdreq1..3           input FIFO pop requests
//   sel1..3    [1:0]    output mux select: 0 = idle word, i = input FIFO i
//   out_valid1..3       output carries a payload word this cycle
//   drop_cnt   [15:0]   packets dropped (destination 0), saturating
// -----------------------------------------------------------------------------
module port_arbiter #(
  parameter int LEN_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        empty1,
  input  logic        empty2,
  input  logic        empty3,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  output logic        rdreq1,
  output logic        rdreq2,
  output logic        rdreq3,
  output logic [1:0]  sel1,
  output logic [1:0]  sel2,
  output logic [1:0]  sel3,
  output logic        out_valid1,
  output logic        out_valid2,
  output logic        out_valid3,
  output logic [15:0] drop_cnt
);

  localparam int NP = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_XFER,
    S_DROP
  } state_e;

  // Index 0..2 below stands for input/output 1..3; owner and pointer values
  // use the external numbering (0 = none, 1..3).
  logic             empty_w  [NP];
  logic [31:0]      data_w   [NP];

  state_e           state_q  [NP];
  state_e           state_d  [NP];
  logic [1:0]       dst_q    [NP];
  logic [1:0]       dst_d    [NP];
  logic [LEN_W-1:0] len_q    [NP];
  logic [LEN_W-1:0] len_d    [NP];
  logic [LEN_W-1:0] issued_q [NP];
  logic [LEN_W-1:0] issued_d [NP];
  logic             rd_req   [NP];
  logic             rd_q     [NP];
  logic             done     [NP];
  logic             drop_done[NP];
  logic             granted  [NP];

  logic [1:0]       owner_q  [NP];
  logic [1:0]       owner_d  [NP];
  logic [1:0]       ptr_q    [NP];
  logic [1:0]       ptr_d    [NP];
  logic [NP-1:0]    req_vec  [NP];
  logic [1:0]       winner   [NP];
  logic             ov       [NP];

  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;
  logic [16:0]      drop_sum;

  // Only header fields are decoded here; payload bits bypass the block.
  logic unused_data_bits;
  assign unused_data_bits = ^{data1[31:LEN_W+2], data2[31:LEN_W+2], data3[31:LEN_W+2]};

  assign empty_w[0] = empty1;
  assign empty_w[1] = empty2;
  assign empty_w[2] = empty3;
  assign data_w[0]  = data1;
  assign data_w[1]  = data2;
  assign data_w[2]  = data3;

  // First requester at or after ptr, scanning 1,2,3 with wrap; 0 if none.
  function automatic logic [1:0] rr_pick(input logic [NP-1:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = 2'd0;
    cand = ptr;
    for (int k = 0; k < NP; k++) begin
      if (pick == 2'd0 && req[cand - 2'd1]) pick = cand;
      cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
    end
    return pick;
  endfunction

  // Status derived from registers only, kept apart from the next-state logic
  // so no combinational block both feeds and reads another.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      // Last word is on data_i the cycle after its rdreq; that is the exit cycle.
      done[i] = (state_q[i] == S_XFER) && (issued_q[i] == len_q[i]);
    end
    for (int o = 0; o < NP; o++) begin
      req_vec[o] = '0;
      for (int i = 0; i < NP; i++) begin
        req_vec[o][i] = (state_q[i] == S_REQ) && (dst_q[i] == 2'(o + 1));
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      winner[o] = rr_pick(req_vec[o], ptr_q[o]);
    end
  end

  // A free output hands itself to its winner; the owner register is not free
  // again until the edge after release, so release and regrant never coincide.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      granted[i] = 1'b0;
      for (int o = 0; o < NP; o++) begin
        if (owner_q[o] == 2'd0 && winner[o] == 2'(i + 1)) granted[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) begin
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (owner_q[o] == 2'd0) begin
        if (winner[o] != 2'd0) begin
          owner_d[o] = winner[o];
          ptr_d[o]   = (winner[o] == 2'd3) ? 2'd1 : winner[o] + 2'd1;
        end
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (owner_q[o] == 2'(i + 1) && done[i]) owner_d[o] = 2'd0;
        end
      end
    end
  end

  // Per-input packet FSM.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      // NOTE: every output of a combinational block gets a default before the
      // case, otherwise the paths that skip an assignment infer a latch.
      state_d[i]   = state_q[i];
      dst_d[i]     = dst_q[i];
      len_d[i]     = len_q[i];
      issued_d[i]  = issued_q[i];
      rd_req[i]    = 1'b0;
      drop_done[i] = 1'b0;
      case (state_q[i])
        S_IDLE: begin
          if (!empty_w[i]) begin
            rd_req[i]  = 1'b1;
            state_d[i] = S_HDR;
          end
        end
        S_HDR: begin
          dst_d[i]    = data_w[i][1:0];
          len_d[i]    = data_w[i][LEN_W+1:2];
          issued_d[i] = '0;
          if (data_w[i][1:0] == 2'd0) begin
            if (data_w[i][LEN_W+1:2] == '0) begin
              // Header-only drop: counted now, nothing more to pop.
              drop_done[i] = 1'b1;
              state_d[i]   = S_IDLE;
            end else begin
              state_d[i] = S_DROP;
            end
          end else if (data_w[i][LEN_W+1:2] == '0) begin
            state_d[i] = S_IDLE;
          end else begin
            state_d[i] = S_REQ;
          end
        end
        S_REQ: begin
          if (granted[i]) state_d[i] = S_XFER;
        end
        S_XFER, S_DROP: begin
          if (issued_q[i] == len_q[i]) begin
            state_d[i]   = S_IDLE;
            drop_done[i] = (state_q[i] == S_DROP);
          end else if (!empty_w[i]) begin
            // An empty FIFO simply stalls: counter and grant are held.
            rd_req[i]   = 1'b1;
            issued_d[i] = issued_q[i] + LEN_W'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NP; i++) begin
      drop_sum = drop_sum + 17'(drop_done[i]);
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        state_q[i]  <= S_IDLE;
        dst_q[i]    <= 2'd0;
        len_q[i]    <= '0;
        issued_q[i] <= '0;
        rd_q[i]     <= 1'b0;
        owner_q[i]  <= 2'd0;
        ptr_q[i]    <= 2'd1;
      end
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        state_q[i]  <= state_d[i];
        dst_q[i]    <= dst_d[i];
        len_q[i]    <= len_d[i];
        issued_q[i] <= issued_d[i];
        rd_q[i]     <= rd_req[i];
        owner_q[i]  <= owner_d[i];
        ptr_q[i]    <= ptr_d[i];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // The word on data_i is payload exactly when the owning input popped last
  // cycle; the owner is in XFER from grant to release, so header pops never
  // show up here.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      ov[o] = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (owner_q[o] == 2'(i + 1) && rd_q[i]) ov[o] = 1'b1;
      end
    end
  end

  // IDLE pops combinationally from !empty, so the pop requests are gated
  // with reset to keep them low while reset is held.
  assign rdreq1     = reset & rd_req[0];
  assign rdreq2     = reset & rd_req[1];
  assign rdreq3     = reset & rd_req[2];
  assign sel1       = owner_q[0];
  assign sel2       = owner_q[1];
  assign sel3       = owner_q[2];
  assign out_valid1 = ov[0];
  assign out_valid2 = ov[1];
  assign out_valid3 = ov[2];
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter: LEN_W, 6, width of the packet length field and of each word counter.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 empty1, empty2, empty3  in  1 each  input FIFO i empty flag.
REQ-005 data1, data2, data3  in  32 each  input FIFO i q output; valid one clk after rdreq (non-show-ahead).
REQ-006 rdreq1, rdreq2, rdreq3  out  1 each  pop request to input FIFO i.
REQ-007 sel1, sel2, sel3  out  2 each  output mux o select: 0 = idle word (data0), i = FIFO i.
REQ-008 out_valid1, out_valid2, out_valid3  out  1 each  output o carries a valid packet word this cycle.
REQ-009 drop_cnt  out  16  count of packets dropped (destination 0), saturating at 16'hFFFF.

Function
REQ-010 Packet: header word then N payload words; header[1:0] = destination output (1..3, 0 = drop), header[LEN_W+1:2] = N; N = 0 is header-only.
REQ-011 Header is consumed by the block and never forwarded; only payload words reach an output.
REQ-012 Each input i runs its own FSM: IDLE, HDR, REQ, XFER, DROP.
REQ-013 IDLE: if !empty_i, assert rdreq_i one cycle, go HDR; else stay.
REQ-014 HDR: latch dst = data_i[1:0], len = N; dst 0 -> DROP; N 0 -> IDLE; else -> REQ.
REQ-015 REQ: raise request to output dst; stay until granted, then XFER.
REQ-016 XFER: assert rdreq_i in each cycle with !empty_i and issued < len; increment issued per rdreq.
REQ-017 XFER exits to IDLE in the cycle after the last word's rdreq (last word on data_i); grant is released at that edge.
REQ-018 DROP: pop len words as in XFER with no output; on exit drop_cnt increments by 1.
REQ-019 Header-only packet with dst 0 increments drop_cnt and pops nothing further.
REQ-020 Empty mid-packet: rdreq_i low, counter held, grant held; resumes without word loss or duplication.
REQ-021 rdreq_i never asserted while empty_i = 1.
REQ-022 Each output o has an owner register (none or input i) and a round-robin pointer.
REQ-023 Output with no owner grants one cycle after requests present; winner is first requester at or after pointer in order 1,2,3 wrapping.
REQ-024 On grant the pointer moves to winner+1 (3 wraps to 1).
REQ-025 Owned output grants nothing; other requesters wait in REQ.
REQ-026 Different outputs grant independently in the same cycle; up to 3 transfers concurrent.
REQ-027 sel_o = owner index from grant until the cycle after the last rdreq inclusive; else 0.
REQ-028 out_valid_o = 1 exactly in cycles where owner's data_i holds a payload word (rdreq_i delayed one cycle).
REQ-029 Release and new grant to the same output may not occur in the same cycle; next grant at least one cycle later.

Reset
REQ-030 While reset = 0: all FSMs IDLE, owners none, pointers 1, counters 0, drop_cnt 0, rdreq*/out_valid* 0, sel* 0.
REQ-031 Reset mid-packet aborts the transfer; partial packet words left in FIFOs are not recovered by the block.
REQ-032 First rdreq may assert in the first clk edge after reset deasserts.

Verification
REQ-033 FIFO1 holds {hdr dst=2 N=3, A,B,C} -> rdreq1 pops 4; sel2=1 over transfer; out_valid2 high 3 cycles carrying A,B,C; sel1=sel3=0.
REQ-034 FIFO1, FIFO3 both hold dst=1 N=2 simultaneously, pointer=1 -> input 1 served first, input 3 next; pointer ends at 1 (3+1 wraps); no interleaving.
REQ-035 FIFO1 dst=1, FIFO2 dst=2, FIFO3 dst=3, N=4 each -> three transfers overlap; each out_valid high 4 cycles.
REQ-036 Header dst=0 N=5 followed by dst=3 N=1 -> 5 words discarded, drop_cnt 0->1, then one word on output 3.
REQ-037 dst=2 N=4 with empty1 asserted after word 2 for 3 cycles -> rdreq1 low during gap, sel2 held at 1, exactly 4 out_valid2 pulses.
REQ-038 reset pulsed low during XFER word 2 -> all outputs 0 immediately; after release FSMs IDLE, owners none.
